mpi_target: RTL and testbench
=============================

Name: mpi_target

Overview:
- Bus responder (target) for the CPU's SYNC/DIN/DOUT/WTBT/RPLY bus; the CPU bus interface is the initiator.
- Decodes a fixed address window and latches the address on the SYNC rising edge.
- Turns DATI/DATO cycles into single-cycle read/write strobes toward a local memory or register file, then returns RPLY after a programmable number of wait states.
- Sits beside RAM/ROM/peripheral blocks on the system bus.

Parameters:
- BASE, 16'o100000: first byte address of the window; must be aligned to 2^(AW+1).
- AW, 13: local word-address width; window size is 2^(AW+1) bytes.
- WAIT_STATES, 0: extra ce-cycles inserted before RPLY; range 0..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce  in  1  clock enable; all state advances only when ce=1
- sync_i  in  1  SYNC from initiator; address valid while high
- din_i  in  1  DIN, read cycle
- dout_i  in  1  DOUT, write cycle; data_i valid
- wtbt_i  in  1  byte operation flag
- addr_i  in  16  byte address
- data_i  in  16  write data from initiator
- rply_o  out  1  RPLY to initiator
- data_o  out  16  read data to initiator
- data_oe_o  out  1  high while data_o carries valid read data
- mem_addr_o  out  AW  local word address
- mem_rd_o  out  1  one-ce-cycle read strobe
- mem_rdata_i  in  16  local read data
- mem_rvalid_i  in  1  mem_rdata_i valid, any latency
- mem_wr_o  out  1  one-ce-cycle write strobe
- mem_be_o  out  2  byte enables, bit0 = low byte
- mem_wdata_o  out  16  write data

Behaviour:
- Reset: synchronous; acts on the clk edge regardless of ce. State goes to IDLE. All outputs go to 0, including the internal sync sample.
- Hit: (addr_i & ~(2^(AW+1)-1)) == BASE.
- mem_addr_o = addr_i[AW:1]. Bit 0 is ignored for word access.
- Byte enables:
  - wtbt=0: be=11.
  - wtbt=1, addr[0]=0: be=01.
  - wtbt=1, addr[0]=1: be=10.
  - Byte write data is taken from the addressed lane of data_i and passed unchanged in mem_wdata_o.
- Byte reads return the full word; the initiator selects the lane.
- States: IDLE, ADDR, RD_WAIT, WAIT, REPLY, IGNORE.
- IDLE: on a ce edge with sync_i=1 and the previous sampled sync=0:
  - Miss: go to IGNORE. No outputs change.
  - Hit: latch addr, wtbt, and addr[0].
    - din_i=1: mem_rd_o=1 for the next ce-cycle; go to RD_WAIT.
    - dout_i=1: latch data_i into mem_wdata_o and set mem_be_o. mem_wr_o=1 for the next ce-cycle. If WAIT_STATES=0 go to REPLY, else go to WAIT.
    - Neither asserted: go to ADDR.
- ADDR: sample din_i/dout_i each ce edge and act exactly as IDLE would on a hit. If sync_i=0, return to IDLE.
- RD_WAIT: on the edge where mem_rvalid_i=1, latch mem_rdata_i into data_o. If WAIT_STATES=0 go to REPLY, else go to WAIT.
- WAIT: counter loaded with WAIT_STATES-1, decrements per ce. At 0, go to REPLY.
- REPLY:
  - rply_o=1.
  - data_oe_o=1 only for read cycles.
  - Hold until an edge samples din_i=0 and dout_i=0, then go to IDLE. rply_o and data_oe_o fall after that edge.
  - data_o keeps its last value after release.
- IGNORE: wait for sync_i=0, then go to IDLE.
- Latency:
  - Write: rply_o rises after edge E0+1+WAIT_STATES, where E0 is the accepting edge.
  - Read: rply_o rises after edge Ev+WAIT_STATES, where Ev is the edge that samples mem_rvalid_i.
- Abort: if sync_i=0 at any ce edge in ADDR, RD_WAIT, or WAIT:
  - Go to IDLE with no RPLY.
  - A late mem_rvalid_i is ignored.
  - A write strobe already issued is not undone.
- A new cycle requires a fresh SYNC rising edge. A SYNC held high after REPLY is not re-accepted.
- mem_rd_o and mem_wr_o are never high together and are never high for more than one ce-cycle per bus cycle.
- With ce=0, all state and outputs hold.

Test Plan:
- Reset: assert reset for 2 clk with ce=0 -> every output is 0 and state is IDLE. Release reset, raise sync+din at 0o100000 -> cycle proceeds normally.
- Word read, WAIT_STATES=0: memory returns rvalid one ce after mem_rd_o with rdata=16'o123456 at 0o100004 -> mem_addr_o=2, single mem_rd_o pulse. rply_o rises after the rvalid-sampling edge, data_o=16'o123456, data_oe_o=1. rply_o drops one ce after din is released.
- Byte write, odd address, WAIT_STATES=3: DOUT to 0o100011 with wtbt=1 and data_i=16'o125000 -> mem_be_o=10, mem_addr_o=4, one mem_wr_o pulse. rply_o rises after edge E0+4.
- Address miss: SYNC+DIN at 0o040000 -> no strobes, rply_o stays 0 for the whole cycle. The next hit cycle is accepted normally.
- Abort: SYNC+DIN at a hit address, drop sync before rvalid, then assert rvalid -> rply_o stays 0, state returns to IDLE, data_o is unchanged.
- ce gating and back-to-back: toggle ce every other clk and run a write then a read to the same word -> reads back the written value. Latencies count ce-cycles only. No acceptance without a new SYNC edge.

Source files
------------

// File: rtl/mpi_target.sv
// mpi_target: bus target for the SYNC/DIN/DOUT/WTBT/RPLY bus.
// Decodes a fixed address window and turns bus cycles into single-cycle
// read/write strobes toward local memory. RPLY is returned after a
// programmable number of wait states.
module mpi_target #(
  parameter logic [15:0] BASE        = 16'o100000,
  parameter int unsigned AW          = 32'd13,
  parameter int unsigned WAIT_STATES = 32'd0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  input  logic          sync_i,
  input  logic          din_i,
  input  logic          dout_i,
  input  logic          wtbt_i,
  input  logic [15:0]   addr_i,
  input  logic [15:0]   data_i,
  output logic          rply_o,
  output logic [15:0]   data_o,
  output logic          data_oe_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_rd_o,
  input  logic [15:0]   mem_rdata_i,
  input  logic          mem_rvalid_i,
  output logic          mem_wr_o,
  output logic [1:0]    mem_be_o,
  output logic [15:0]   mem_wdata_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WAIT    = 3'd3,
    S_REPLY   = 3'd4,
    S_IGNORE  = 3'd5
  } state_e;

  localparam logic [15:0] WIN_MASK = 16'((32'd1 << (AW + 32'd1)) - 32'd1);
  localparam bit          WS_ZERO  = (WAIT_STATES == 32'd0);
  localparam int unsigned WS_M1    = WS_ZERO ? 32'd0 : (WAIT_STATES - 32'd1);
  localparam logic [3:0]  WS_LOAD  = 4'(WS_M1);

  // Byte-lane enables: word access drives both lanes, byte access the addressed one.
  function automatic logic [1:0] byte_en(input logic wtbt, input logic a0);
    logic [1:0] be;
    if (!wtbt) begin
      be = 2'b11;
    end else if (a0) begin
      be = 2'b10;
    end else begin
      be = 2'b01;
    end
    return be;
  endfunction

  state_e          state_q, state_d;
  logic            sync_q, sync_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            is_rd_q, is_rd_d;
  logic            wtbt_q, wtbt_d;
  logic            a0_q, a0_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic            mem_rd_q, mem_rd_d;
  logic            mem_wr_q, mem_wr_d;
  logic [1:0]      mem_be_q, mem_be_d;
  logic [15:0]     mem_wdata_q, mem_wdata_d;
  logic [15:0]     data_q, data_d;
  logic            rply_q, rply_d;
  logic            data_oe_q, data_oe_d;

  logic            hit_s;
  logic            sync_rise_s;
  logic            act_wtbt_s;
  logic            act_a0_s;

  assign hit_s       = ((addr_i & ~WIN_MASK) == BASE);
  assign sync_rise_s = sync_i & ~sync_q;
  // In IDLE the cycle attributes come straight off the bus; in ADDR from the latch.
  assign act_wtbt_s  = (state_q == S_IDLE) ? wtbt_i : wtbt_q;
  assign act_a0_s    = (state_q == S_IDLE) ? addr_i[0] : a0_q;

  // Next-state and registered-output computation for one ce-cycle.
  always_comb begin
    logic start_v;
    start_v     = 1'b0;
    state_d     = state_q;
    sync_d      = sync_i;
    cnt_d       = cnt_q;
    is_rd_d     = is_rd_q;
    wtbt_d      = wtbt_q;
    a0_d        = a0_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    data_d      = data_q;
    rply_d      = 1'b0;
    data_oe_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sync_rise_s) begin
          if (hit_s) begin
            mem_addr_d = addr_i[AW:1];
            wtbt_d     = wtbt_i;
            a0_d       = addr_i[0];
            start_v    = 1'b1;
          end else begin
            state_d = S_IGNORE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (!sync_i) begin
          state_d = S_IDLE;
        end else begin
          start_v = 1'b1;
        end
      end
      S_RD_WAIT: begin
        if (!sync_i) begin
          state_d = S_IDLE;
        end else if (mem_rvalid_i) begin
          data_d = mem_rdata_i;
          if (WS_ZERO) begin
            state_d   = S_REPLY;
            rply_d    = 1'b1;
            data_oe_d = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
          end
        end else begin
          state_d = S_RD_WAIT;
        end
      end
      S_WAIT: begin
        if (!sync_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          // Reads reply on entry; writes reply one ce-cycle later so the
          // strobe has completed before RPLY is seen.
          state_d   = S_REPLY;
          rply_d    = is_rd_q;
          data_oe_d = is_rd_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_REPLY: begin
        if (!din_i && !dout_i) begin
          state_d = S_IDLE;
        end else begin
          rply_d    = 1'b1;
          data_oe_d = is_rd_q;
        end
      end
      S_IGNORE: begin
        if (!sync_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_IGNORE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (start_v) begin
      if (din_i) begin
        mem_rd_d = 1'b1;
        is_rd_d  = 1'b1;
        state_d  = S_RD_WAIT;
      end else if (dout_i) begin
        mem_wdata_d = data_i;
        mem_be_d    = byte_en(act_wtbt_s, act_a0_s);
        mem_wr_d    = 1'b1;
        is_rd_d     = 1'b0;
        if (WS_ZERO) begin
          state_d = S_REPLY;
        end else begin
          state_d = S_WAIT;
          cnt_d   = WS_LOAD;
        end
      end else begin
        state_d = S_ADDR;
      end
    end else begin
      is_rd_d = is_rd_d;
    end
  end

  // State and output registers; synchronous reset wins over ce.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sync_q      <= 1'b0;
      cnt_q       <= 4'd0;
      is_rd_q     <= 1'b0;
      wtbt_q      <= 1'b0;
      a0_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_be_q    <= 2'b00;
      mem_wdata_q <= 16'd0;
      data_q      <= 16'd0;
      rply_q      <= 1'b0;
      data_oe_q   <= 1'b0;
    end else if (ce) begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      is_rd_q     <= is_rd_d;
      wtbt_q      <= wtbt_d;
      a0_q        <= a0_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      data_q      <= data_d;
      rply_q      <= rply_d;
      data_oe_q   <= data_oe_d;
    end
  end

  assign rply_o      = rply_q;
  assign data_o      = data_q;
  assign data_oe_o   = data_oe_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_rd_o    = mem_rd_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mpi_target.sv
// tb_mpi_target: directed bench for mpi_target. Two instances share the bus
// inputs: u_dut0 with no wait states and u_dut3 with three wait states.
module tb_mpi_target;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        sync, din, dout, wtbt;
  logic [15:0] addr, wdata_in, rdata;
  logic        rvalid;
  logic        gate = 1'b0;

  logic        rply0, oe0, rd0, wr0;
  logic [15:0] data0, wdata0;
  logic [12:0] maddr0;
  logic [1:0]  be0;
  logic        rply3, oe3, rd3, wr3;
  logic [15:0] data3, wdata3;
  logic [12:0] maddr3;
  logic [1:0]  be3;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] mem_m [0:15];

  always #5 clk = ~clk;

  mpi_target #(.BASE(16'o100000), .AW(32'd13), .WAIT_STATES(32'd0)) u_dut0 (
    .clk(clk), .reset(reset), .ce(ce), .sync_i(sync), .din_i(din), .dout_i(dout),
    .wtbt_i(wtbt), .addr_i(addr), .data_i(wdata_in), .rply_o(rply0), .data_o(data0),
    .data_oe_o(oe0), .mem_addr_o(maddr0), .mem_rd_o(rd0), .mem_rdata_i(rdata),
    .mem_rvalid_i(rvalid), .mem_wr_o(wr0), .mem_be_o(be0), .mem_wdata_o(wdata0));

  mpi_target #(.BASE(16'o100000), .AW(32'd13), .WAIT_STATES(32'd3)) u_dut3 (
    .clk(clk), .reset(reset), .ce(ce), .sync_i(sync), .din_i(din), .dout_i(dout),
    .wtbt_i(wtbt), .addr_i(addr), .data_i(wdata_in), .rply_o(rply3), .data_o(data3),
    .data_oe_o(oe3), .mem_addr_o(maddr3), .mem_rd_o(rd3), .mem_rdata_i(rdata),
    .mem_rvalid_i(rvalid), .mem_wr_o(wr3), .mem_be_o(be3), .mem_wdata_o(wdata3));

  // Local memory model behind u_dut0: commits a write at the ce edge ending the strobe.
  always @(posedge clk) begin
    if (!reset && ce && wr0) begin
      if (be0[0]) mem_m[maddr0[3:0]][7:0]  <= wdata0[7:0];
      if (be0[1]) mem_m[maddr0[3:0]][15:8] <= wdata0[15:8];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next ce edge (every other clk when gated).
  task automatic ce_tick();
    if (gate) begin
      ce = 1'b0;
      @(posedge clk); #1;
      ce = 1'b1;
      @(posedge clk); #1;
      ce = 1'b0;
    end else begin
      ce = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic bus(input logic s, input logic di, input logic dw, input logic w,
                     input logic [15:0] a, input logic [15:0] d);
    sync = s; din = di; dout = dw; wtbt = w; addr = a; wdata_in = d;
  endtask

  initial begin
    logic bad;
    reset = 1'b1; ce = 1'b0; rvalid = 1'b0; rdata = 16'd0;
    bus(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);

    // Reset with ce low
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("rst_rply", {31'd0, rply0}, 32'd0);
    check_eq("rst_data", {16'd0, data0}, 32'd0);
    check_eq("rst_oe", {31'd0, oe0}, 32'd0);
    check_eq("rst_addr", {19'd0, maddr0}, 32'd0);
    check_eq("rst_strobes", {29'd0, rd0, wr0, rply3}, 32'd0);
    check_eq("rst_be_wd", {14'd0, be0, wdata0}, 32'd0);
    reset = 1'b0; ce = 1'b1;

    // First cycle after reset
    bus(1'b1, 1'b1, 1'b0, 1'b0, 16'o100000, 16'd0);
    ce_tick();
    check_eq("r0_rd", {31'd0, rd0}, 32'd1);
    check_eq("r0_addr", {19'd0, maddr0}, 32'd0);
    rvalid = 1'b1; rdata = 16'o000777;
    ce_tick();
    check_eq("r0_rply", {31'd0, rply0}, 32'd1);
    check_eq("r0_data", {16'd0, data0}, 32'o000777);
    rvalid = 1'b0;
    bus(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    ce_tick(); ce_tick();

    // Word read at 0o100004, rvalid one ce after the strobe
    bus(1'b1, 1'b1, 1'b0, 1'b0, 16'o100004, 16'd0);
    ce_tick();
    check_eq("rd_strobe", {31'd0, rd0}, 32'd1);
    check_eq("rd_addr", {19'd0, maddr0}, 32'd2);
    ce_tick();
    check_eq("rd_single", {30'd0, rd0, rply0}, 32'd0);
    rvalid = 1'b1; rdata = 16'o123456;
    ce_tick();
    check_eq("rd_rply", {30'd0, rply0, oe0}, 32'd3);
    check_eq("rd_data", {16'd0, data0}, 32'o123456);
    rvalid = 1'b0;
    ce_tick();
    check_eq("rd_hold", {31'd0, rply0}, 32'd1);
    din = 1'b0;
    ce_tick();
    check_eq("rd_release", {30'd0, rply0, oe0}, 32'd0);
    check_eq("rd_keep", {16'd0, data0}, 32'o123456);
    bus(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    ce_tick(); ce_tick();

    // Byte write to odd address; u_dut3 has three wait states
    bus(1'b1, 1'b0, 1'b1, 1'b1, 16'o100011, 16'o125000);
    ce_tick(); // E0
    check_eq("bw_wr", {31'd0, wr3}, 32'd1);
    check_eq("bw_be", {30'd0, be3}, 32'd2);
    check_eq("bw_addr", {19'd0, maddr3}, 32'd4);
    check_eq("bw_wdata", {16'd0, wdata3}, 32'o125000);
    check_eq("w0_rply_e0", {31'd0, rply0}, 32'd0);
    ce_tick(); // E0+1
    check_eq("bw_wr_once", {31'd0, wr3}, 32'd0);
    check_eq("w0_rply_e1", {31'd0, rply0}, 32'd1);
    ce_tick(); ce_tick(); // E0+3
    check_eq("bw_rply_e3", {31'd0, rply3}, 32'd0);
    ce_tick(); // E0+4
    check_eq("bw_rply_e4", {31'd0, rply3}, 32'd1);
    check_eq("bw_oe", {31'd0, oe3}, 32'd0);
    dout = 1'b0;
    ce_tick();
    check_eq("bw_release", {31'd0, rply3}, 32'd0);
    bus(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    ce_tick(); ce_tick();

    // Address miss, then a normal hit
    bus(1'b1, 1'b1, 1'b0, 1'b0, 16'o040000, 16'd0);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ce_tick();
      if (rd0 || wr0 || rply0 || rd3 || rply3) bad = 1'b1;
    end
    check_eq("miss_quiet", {31'd0, bad}, 32'd0);
    bus(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    ce_tick();
    bus(1'b1, 1'b1, 1'b0, 1'b0, 16'o100002, 16'd0);
    ce_tick();
    check_eq("hit_rd", {31'd0, rd0}, 32'd1);
    rvalid = 1'b1; rdata = 16'o054321;
    ce_tick();
    check_eq("hit_rply", {31'd0, rply0}, 32'd1);
    rvalid = 1'b0;
    bus(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    ce_tick(); ce_tick();

    // Abort before rvalid; the late rvalid must be ignored
    bus(1'b1, 1'b1, 1'b0, 1'b0, 16'o100006, 16'd0);
    ce_tick();
    check_eq("ab_rd", {31'd0, rd0}, 32'd1);
    ce_tick();
    sync = 1'b0;
    ce_tick();
    rvalid = 1'b1; rdata = 16'o007777;
    ce_tick(); ce_tick();
    check_eq("ab_norply", {30'd0, rply0, oe0}, 32'd0);
    check_eq("ab_data", {16'd0, data0}, 32'o054321);
    rvalid = 1'b0;
    bus(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    ce_tick();
    bus(1'b1, 1'b1, 1'b0, 1'b0, 16'o100006, 16'd0);
    ce_tick();
    check_eq("ab_idle_again", {31'd0, rd0}, 32'd1);
    rvalid = 1'b1; rdata = 16'o000123;
    ce_tick();
    check_eq("ab_next_data", {16'd0, data0}, 32'o000123);
    rvalid = 1'b0;
    bus(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    ce_tick(); ce_tick();

    // ce every other clk: write then read back the same word
    gate = 1'b1;
    bus(1'b1, 1'b0, 1'b1, 1'b0, 16'o100020, 16'o111222);
    ce_tick();
    check_eq("ce_wr", {31'd0, wr0}, 32'd1);
    check_eq("ce_be", {30'd0, be0}, 32'd3);
    check_eq("ce_addr", {19'd0, maddr0}, 32'd8);
    @(posedge clk); #1; // ce low: strobe must hold
    check_eq("ce_hold_wr", {31'd0, wr0}, 32'd1);
    ce_tick();
    check_eq("ce_wr_done", {31'd0, wr0}, 32'd0);
    check_eq("ce_wrply", {31'd0, rply0}, 32'd1);
    dout = 1'b0;
    ce_tick();
    check_eq("ce_wrel", {31'd0, rply0}, 32'd0);
    din = 1'b1; // SYNC still high from the write: must not be accepted
    ce_tick();
    check_eq("no_reaccept", {30'd0, rd0, rply0}, 32'd0);
    bus(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    ce_tick();
    bus(1'b1, 1'b1, 1'b0, 1'b0, 16'o100020, 16'd0);
    ce_tick();
    check_eq("ce_rd", {31'd0, rd0}, 32'd1);
    rdata = mem_m[maddr0[3:0]]; rvalid = 1'b1;
    ce_tick();
    check_eq("ce_rply", {31'd0, rply0}, 32'd1);
    check_eq("ce_readback", {16'd0, data0}, 32'o111222);
    rvalid = 1'b0;
    bus(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    ce_tick();
    check_eq("ce_end", {31'd0, rply0}, 32'd0);
    gate = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
